// File: rtl/four_input_activation_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : four_input_activation_pkg
//  Description : Shared widths, constants, 2^(k/16) table and FSM state type
//                for the fixed-point logistic activation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package four_input_activation_pkg;

    localparam int IN_W      = 16;   // signed Q8.8 input
    localparam int OUT_W     = 16;   // unsigned Q1.15 sigmoid result
    localparam int ACT_W     = 32;   // unsigned Q16.16 exponential
    localparam int DIV_W     = 33;   // divisor width: 1.0 + activation
    localparam int DIV_STEPS = 16;   // one quotient bit per cycle

    // log2(e) in Q8.8 (1.44140625)
    localparam logic signed [IN_W-1:0] LOG2E = 16'sh0171;

    // 2^(k/16) in Q1.15 for k = 0..16; the last entry (2.0) needs a 17th bit
    localparam logic [16:0] EXP2_LUT [0:16] = '{
        17'd32768, 17'd34219, 17'd35734, 17'd37316,
        17'd38968, 17'd40693, 17'd42495, 17'd44376,
        17'd46341, 17'd48393, 17'd50535, 17'd52773,
        17'd55109, 17'd57549, 17'd60097, 17'd62758,
        17'd65536
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/four_input_activation_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : four_input_activation_if
//  Description : Input handshake and result bundle of the activation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface four_input_activation_if;
    import four_input_activation_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   a_input;
    logic              out_valid;
    logic [OUT_W-1:0]  out;
    logic [ACT_W-1:0]  activation;

    modport master (
        output in_valid, a_input,
        input  in_ready, out_valid, out, activation
    );

    modport slave (
        input  in_valid, a_input,
        output in_ready, out_valid, out, activation
    );

endinterface
`default_nettype wire

// File: rtl/act_div_restoring.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : act_div_restoring
//  Description : Sequential restoring divider, 33-bit divisor, 16 quotient
//                bits, one bit per cycle. The caller guarantees that the
//                quotient fits in 16 bits (dividend[31:16] < divisor), so the
//                upper half of the dividend seeds the partial remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module act_div_restoring
    import four_input_activation_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ACT_W-1:0]  i_dividend,
    input  logic [DIV_W-1:0]  i_divisor,
    output logic [OUT_W-1:0]  o_quotient,
    output logic              o_busy,
    output logic              o_done
);

    logic [DIV_W-1:0]  r_rem;
    logic [15:0]       r_num_lo;
    logic [DIV_W-1:0]  r_div;
    logic [OUT_W-1:0]  r_quo;
    logic [3:0]        r_cnt;
    logic              r_busy;

    logic [DIV_W:0]    w_trial;
    logic              w_ge;
    logic [DIV_W-1:0]  w_diff;

    // Shift in the next dividend bit and trial-subtract the divisor; the
    // difference only matters when it is non-negative, so 33 bits suffice.
    always_comb begin
        w_trial = {r_rem, r_num_lo[15]};
        w_ge    = (w_trial >= {1'b0, r_div});
        w_diff  = w_trial[DIV_W-1:0] - r_div;
    end

    // Load on start, then retire one quotient bit per cycle for 16 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_num_lo <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_rem    <= {17'd0, i_dividend[31:16]};
            r_num_lo <= i_dividend[15:0];
            r_div    <= i_divisor;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_rem    <= w_ge ? w_diff : w_trial[DIV_W-1:0];
            r_num_lo <= {r_num_lo[14:0], 1'b0};
            r_quo    <= {r_quo[OUT_W-2:0], w_ge};
            r_cnt    <= r_cnt + 4'd1;
            if (r_cnt == 4'(DIV_STEPS - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // o_done flags the cycle whose closing edge writes the final quotient bit
    assign o_quotient = r_quo;
    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == 4'(DIV_STEPS - 1));

endmodule
`default_nettype wire

// File: rtl/four_input_activation.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : four_input_activation
//  Description : Fixed-point sigmoid stage. Computes activation = e^a as
//                2^(a*log2e) with a 17-entry interpolated LUT, then
//                out = 2^31 / (2^16 + activation) with a restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module four_input_activation
    import four_input_activation_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    four_input_activation_if.slave bus
);

    state_t                   r_state;
    state_t                   w_state_next;

    logic signed [IN_W-1:0]   r_a;
    logic [OUT_W-1:0]         r_out;
    logic [ACT_W-1:0]         r_act;
    logic                     r_out_valid;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_div_start;
    logic                     w_load_out;

    logic signed [31:0]       w_prod;
    logic signed [31:0]       w_y;
    logic signed [31:0]       w_n;
    logic [7:0]               w_f;
    logic [3:0]               w_idx;
    logic [4:0]               w_idx_hi;
    logic [3:0]               w_frac;
    logic [16:0]              w_lo;
    logic [16:0]              w_hi;
    logic [16:0]              w_delta;
    logic [20:0]              w_interp;
    logic [16:0]              w_mant;
    logic [ACT_W-1:0]         w_base;
    logic [4:0]               w_shamt;
    logic [ACT_W-1:0]         w_exp;

    logic [DIV_W-1:0]         w_divisor;
    logic [OUT_W-1:0]         w_quo;
    logic                     w_div_busy;
    logic                     w_div_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> EXP -> DIV (16 cycles) -> DONE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_next = EXP;
            EXP:                     w_state_next = DIV;
            DIV:     if (w_div_done) w_state_next = DONE;
            DONE:                    w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_in_ready  = 1'b0;
        w_div_start = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = !w_div_busy;
            EXP:     w_div_start = 1'b1;
            DONE:    w_load_out  = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = bus.in_valid && w_in_ready;

    // Capture the operand; it stays stable until the next accept, so the
    // exponential below remains valid through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (w_accept) begin
            r_a <= bus.a_input;
        end
    end

    // e^a = 2^y with y = a*log2e. y is kept wider than Q8.8 so large
    // inputs reach the saturation tests instead of wrapping.
    always_comb begin
        w_prod   = r_a * LOG2E;
        w_y      = w_prod >>> 8;
        w_n      = w_y >>> 8;
        w_f      = w_y[7:0];
        w_idx    = w_f[7:4];
        w_frac   = w_f[3:0];
        w_idx_hi = {1'b0, w_idx} + 5'd1;
        w_lo     = EXP2_LUT[w_idx];
        w_hi     = EXP2_LUT[w_idx_hi];
        w_delta  = w_hi - w_lo;
        w_interp = {4'd0, w_delta} * {17'd0, w_frac};
        w_mant   = w_lo + 17'(w_interp >> 4);
        w_base   = {14'd0, w_mant, 1'b0};
        w_shamt  = w_n[31] ? 5'(-w_n) : 5'(w_n);
    end

    // Scale 2^f by 2^n, saturating at both ends
    always_comb begin
        w_exp = '0;
        if (w_n >= 32'sd15) begin
            w_exp = '1;
        end else if (w_n <= -32'sd17) begin
            w_exp = '0;
        end else if (w_n[31]) begin
            w_exp = w_base >> w_shamt;
        end else begin
            w_exp = w_base << w_shamt;
        end
    end

    assign w_divisor = 33'h1_0000 + {1'b0, w_exp};

    act_div_restoring u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (32'h8000_0000),
        .i_divisor  (w_divisor),
        .o_quotient (w_quo),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done)
    );

    // Result registers: updated and flagged together in DONE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_act       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_load_out;
            if (w_load_out) begin
                r_out <= w_quo;
                r_act <= w_exp;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out        = r_out;
    assign bus.activation = r_act;

endmodule
`default_nettype wire

// File: tb/tb_four_input_activation.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_four_input_activation
//  Description : Self-checking bench for the sigmoid stage: directed table,
//                busy/back-to-back/reset sequences, sweep and random inputs
//                against a real-valued sigmoid/exponential model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_four_input_activation;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    four_input_activation_if ifc ();

    four_input_activation dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] eo;
        int          otol;
        logic [31:0] ea;
        longint      atol;   // negative: activation not checked
    } vec_t;

    vec_t tbl [8];

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic chk(input string name, input bit ok, input longint actual, input longint required);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // One transaction; lat counts edges from accept to the first visible out_valid
    task automatic run_op(input logic [15:0] a, output logic [15:0] o, output logic [31:0] act,
                          output int lat, output int vcyc);
        @(negedge clk);
        chk("in_ready before accept", ifc.in_ready == 1'b1, ifc.in_ready, 1);
        ifc.in_valid = 1'b1;
        ifc.a_input  = a;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (ifc.out_valid) break;
        end
        o    = ifc.out;
        act  = ifc.activation;
        vcyc = cyc;
    endtask

    // Ideal sigmoid(-a) and e^a, with the tolerances the block promises
    task automatic check_model(input string tag, input logic [15:0] a, input logic [15:0] o,
                               input logic [31:0] act, input int lat);
        real ar, eo, ea;
        ar = real'($signed(a)) / 256.0;
        eo = 32768.0 / (1.0 + $exp(ar));
        chk({tag, " latency"}, lat == 18, lat, 18);
        chk({tag, " out"}, rabs(real'(o) - eo) <= 164.0, o, longint'(eo));
        if (rabs(ar) < 2.0) begin
            ea = $exp(ar) * 65536.0;
            chk({tag, " activation"}, rabs(real'(act) - ea) <= 0.005 * ea, act, longint'(ea));
        end else if (ar >= 11.0) begin
            chk({tag, " activation sat high"}, act == 32'hFFFF_FFFF, act, 32'hFFFF_FFFF);
        end else if (ar <= -12.0) begin
            chk({tag, " activation sat low"}, act == 32'h0, act, 0);
        end
    endtask

    initial begin
        logic [15:0] o, o2, prev;
        logic [31:0] act, act2;
        int          lat, v1, v2, pulses;
        logic [15:0] a;

        tbl[0] = '{16'h0000, 16'h4000, 0,   32'h0001_0000, 0};
        tbl[1] = '{16'h6400, 16'h0000, 0,   32'hFFFF_FFFF, 0};
        tbl[2] = '{16'h9C00, 16'h8000, 0,   32'h0000_0000, 0};
        tbl[3] = '{16'h7FFF, 16'h0000, 0,   32'hFFFF_FFFF, 0};
        tbl[4] = '{16'h8000, 16'h8000, 0,   32'h0000_0000, 0};
        tbl[5] = '{16'hFB00, 16'h7F24, 164, 32'h0,         -1};
        tbl[6] = '{16'h0500, 16'h00DB, 164, 32'h0,         -1};
        tbl[7] = '{16'h0100, 16'h226C, 164, 32'd178145,    890};

        ifc.in_valid = 1'b0;
        ifc.a_input  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset out", ifc.out == 16'h0, ifc.out, 0);
        chk("reset activation", ifc.activation == 32'h0, ifc.activation, 0);
        chk("reset out_valid", ifc.out_valid == 1'b0, ifc.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", ifc.in_ready == 1'b1, ifc.in_ready, 1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, o, act, lat, v1);
            chk($sformatf("vec%0d latency", i), lat == 18, lat, 18);
            chk($sformatf("vec%0d out", i),
                ($signed({1'b0, o}) - $signed({1'b0, tbl[i].eo}) <= tbl[i].otol) &&
                ($signed({1'b0, tbl[i].eo}) - $signed({1'b0, o}) <= tbl[i].otol), o, tbl[i].eo);
            if (tbl[i].atol >= 0) begin
                chk($sformatf("vec%0d activation", i),
                    rabs(real'(act) - real'(tbl[i].ea)) <= real'(tbl[i].atol), act, tbl[i].ea);
            end
            if (i == 0) begin
                @(posedge clk);
                #1;
                chk("out_valid single pulse", ifc.out_valid == 1'b0, ifc.out_valid, 0);
                repeat (3) @(posedge clk);
                #1;
                chk("out held", ifc.out == 16'h4000, ifc.out, 16'h4000);
            end
        end

        // New input offered throughout the busy period must be ignored
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a_input  = 16'h0000;
        @(posedge clk);
        #1;
        ifc.a_input = 16'h0500;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 3) chk("in_ready low while busy", ifc.in_ready == 1'b0, ifc.in_ready, 0);
            if (ifc.out_valid) break;
        end
        ifc.in_valid = 1'b0;
        chk("busy latency", lat == 18, lat, 18);
        chk("busy out unchanged", ifc.out == 16'h4000, ifc.out, 16'h4000);
        chk("busy activation", ifc.activation == 32'h0001_0000, ifc.activation, 32'h0001_0000);
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid) pulses++;
        end
        chk("busy no extra result", pulses == 0, pulses, 0);

        // Back-to-back transactions
        run_op(16'h0100, o, act, lat, v1);
        check_model("b2b first", 16'h0100, o, act, lat);
        run_op(16'hFF00, o2, act2, lat, v2);
        check_model("b2b second", 16'hFF00, o2, act2, lat);
        chk("b2b spacing", (v2 - v1) == 19, v2 - v1, 19);

        // Reset in the middle of DIV aborts
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.a_input  = 16'h0100;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort out", ifc.out == 16'h0, ifc.out, 0);
        chk("abort activation", ifc.activation == 32'h0, ifc.activation, 0);
        chk("abort out_valid", ifc.out_valid == 1'b0, ifc.out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid) pulses++;
        end
        chk("abort no result", pulses == 0, pulses, 0);
        chk("abort in_ready", ifc.in_ready == 1'b1, ifc.in_ready, 1);
        run_op(16'h0000, o, act, lat, v1);
        chk("post reset latency", lat == 18, lat, 18);
        chk("post reset out", o == 16'h4000, o, 16'h4000);

        // Sweep -16.0 .. +16.0 in 0.25 steps
        prev = 16'h0;
        for (int v = -4096; v <= 4096; v += 64) begin
            a = 16'(v);
            run_op(a, o, act, lat, v1);
            check_model($sformatf("sweep %0d", v), a, o, act, lat);
            if (v > -4096) chk($sformatf("sweep mono %0d", v), o <= prev, o, prev);
            prev = o;
        end

        // Random inputs: half concentrated in the transition region
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 16'hFFFF));
            else                           a = 16'(int'($urandom_range(0, 8192)) - 4096);
            run_op(a, o, act, lat, v1);
            check_model($sformatf("rand %0d a=%h", k, a), a, o, act, lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/four_input_activation.md
# four_input_activation

Fixed-point logistic activation stage for the neuron datapath. Takes the negated weighted sum of a neuron (bias included) and produces the sigmoid output out = 1/(1+e^a_input) = sigmoid(−a_input). The intermediate exponential term is also exported on the activation port. It sits after the weighted-sum stage of each output neuron, and replaces the behavioural real-valued activation with synthesizable arithmetic.

## Interface
- No parameters. Widths and constants are fixed in the package.
- clk      input   1   single clock, rising edge.
- rst_n    input   1   asynchronous, active-low reset.
- in_valid    input   1   a_input is valid this cycle.
- in_ready    output  1   block is idle and accepts an input.
- a_input     input   16  signed Q8.8, negated neuron sum, range [−128, 128).
- out_valid   output  1   one-cycle pulse: out and activation are updated.
- out         output  16  unsigned Q1.15 sigmoid result; 1.0 = 16'h8000.
- activation  output  32  unsigned Q16.16 value of e^a_input, saturating.

## Operation
- Accept: in_valid && in_ready captures a_input. in_ready is high only in IDLE.
- Exponential, computed as e^x = 2^(x·log2e):
  - y = (a_input × LOG2E) >>> 8, where LOG2E = 16'h0171 (Q8.8). Signed product, arithmetic shift, y is Q8.8.
  - n = y >>> 8 is the signed integer part. f = y[7:0] is the fraction.
  - 2^f: a 17-entry LUT of 2^(k/16) in Q1.15 (k = 0..16), indexed by f[7:4]. Linear interpolation between entries k and k+1 using f[3:0]/16.
  - activation = (2^f in Q16.16) shifted left by n (n ≥ 0) or right by −n.
  - Saturation: n ≥ 15 gives 32'hFFFF_FFFF. n ≤ −17 gives 0.
- Sigmoid:
  - D = 33'h1_0000 + activation.
  - out = floor(2^31 / D), computed by a restoring divider producing 16 quotient bits.
  - Result range is 0..16'h8000. An activation of 0 gives exactly 16'h8000.
- Accuracy: out must be within ±0.5% of full scale (±164 LSB) of the ideal sigmoid(−a_input). activation must be within ±0.5% relative error, excluding the saturated region.
- out and activation hold their last values between results.

## Timing
- States and transitions:
  - IDLE → EXP on accept.
  - EXP (1 cycle: multiply, LUT lookup, shift) → DIV.
  - DIV (16 cycles, one quotient bit per cycle) → DONE.
  - DONE (1 cycle: register out and activation, pulse out_valid) → IDLE.
- Latency: out_valid is asserted 18 cycles after the accept edge.
- Throughput: one result per 19 cycles.
- in_valid while busy is ignored. No queuing; the input is not captured.
- Reset values: state = IDLE, in_ready = 1 after reset deassertion, out_valid = 0, out = 0, activation = 0.
- Reset mid-operation aborts the computation immediately; no out_valid is produced.
- An accept in the cycle after DONE is legal (back-to-back operation).

## Structure
- Package four_input_activation_pkg holds:
  - Widths: IN_W = 16, OUT_W = 16, ACT_W = 32.
  - LOG2E.
  - The 2^(k/16) LUT as a constant array.
  - The state enum typedef {IDLE, EXP, DIV, DONE}.
- One natural sub-module: act_div_restoring, a 33-bit-divisor sequential restoring divider with start/busy/done. The top level holds the FSM, the exponential datapath and the output registers.

## Test plan
- Accept a_input = 16'h0000 → activation ≈ 32'h0001_0000 and out ≈ 16'h4000 (0.5), out_valid 18 cycles after accept.
- a_input = −5.0 (16'hFB00) → out ≈ 16'h7F24 (0.9933); a_input = +5.0 (16'h0500) → out ≈ 16'h00DB (0.0067), both within ±164 LSB.
- Saturation:
  - a_input = +100.0 (16'h6400) → activation = 32'hFFFF_FFFF and out = 0.
  - a_input = −100.0 (16'h9C00) → activation = 0 and out = 16'h8000.
- Busy rules:
  - Hold in_valid high with a new value during DIV → input is ignored and the first result is unchanged.
  - Back-to-back accepts give one out_valid pulse each, 19 cycles apart.
- Reset handling:
  - Assert rst_n low at cycle 10 of DIV → out_valid is never pulsed, and out and activation are 0.
  - After release, in_ready = 1 and a fresh a_input = 0 yields 16'h4000.
- Sweep a_input from −16.0 to +16.0 in steps of 0.25 → out is monotonically non-increasing and within tolerance against a real-valued model.
